// File: rtl/reg_bank_dump.sv
// 32-entry register file with two combinational read ports and a valid/ready dump streamer.
// Optional same-cycle write-through to the read ports: define REGBANK_BYPASS_EN.
//
// state | meaning
// IDLE  | waiting for DumpStart
// LOAD  | fetching the first beat (r0) into DumpData
// SEND  | presenting beat DumpIndex, advancing on each handshake
// DONE  | one-cycle completion pulse, then back to IDLE
module reg_bank_dump #(
    parameter int DATA_W   = 32,
    parameter int SP_RESET = 227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [4:0]        WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [4:0]        ReadReg1,
    input  logic [4:0]        ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic              DumpStart,
    input  logic              DumpReady,
    output logic              DumpValid,
    output logic [4:0]        DumpIndex,
    output logic [DATA_W-1:0] DumpData,
    output logic              DumpBusy,
    output logic              DumpDone
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_t;

    logic [DATA_W-1:0] regs [32];
    dump_state_t       state, state_nxt;
    logic [4:0]        idx_nxt;
    logic [4:0]        idx_inc;
    logic [DATA_W-1:0] data_nxt;
    logic              wr_en;

    assign wr_en = RegWrite && (WriteReg != 5'd0);

    // r0 is never written, so its reset value of zero holds forever
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == 29) ? DATA_W'(SP_RESET) : '0;
            end
        end else if (wr_en) begin
            regs[WriteReg] <= WriteData;
        end
    end

`ifdef REGBANK_BYPASS_EN
    assign ReadData1 = (wr_en && (WriteReg == ReadReg1)) ? WriteData : regs[ReadReg1];
    assign ReadData2 = (wr_en && (WriteReg == ReadReg2)) ? WriteData : regs[ReadReg2];
`else
    assign ReadData1 = regs[ReadReg1];
    assign ReadData2 = regs[ReadReg2];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            DumpIndex <= '0;
            DumpData  <= '0;
        end else begin
            state     <= state_nxt;
            DumpIndex <= idx_nxt;
            DumpData  <= data_nxt;
        end
    end

    assign idx_inc = DumpIndex + 5'd1;

    // beats are snapshotted from pre-edge contents, so a later write never alters a presented beat
    always_comb begin
        state_nxt = state;
        idx_nxt   = DumpIndex;
        data_nxt  = DumpData;
        case (state)
            IDLE: begin
                if (DumpStart) begin
                    state_nxt = LOAD;
                    idx_nxt   = '0;
                end
            end
            LOAD: begin
                data_nxt  = regs[DumpIndex];
                state_nxt = SEND;
            end
            SEND: begin
                if (DumpReady) begin
                    if (DumpIndex == 5'd31) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt  = idx_inc;
                        data_nxt = regs[idx_inc];
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign DumpValid = (state == SEND);
    assign DumpBusy  = (state == LOAD) || (state == SEND);
    assign DumpDone  = (state == DONE);

endmodule

// File: doc/reg_bank_dump.md
Name: reg_bank_dump

Overview:
- Register bank: 32 x 32-bit general-purpose registers for the multicycle MIPS datapath.
- Write side: a single write port addressed by the register-destination select output (RT/RD/31/29/RS).
- Read side: two combinational read ports, addressed by the RS and RT instruction fields.
- Dump engine: a valid/ready state machine streams all 32 registers out in index order, for bench checking and debug.

Parameters:
- DATA_W, 32, register and data width.
- SP_RESET, 227, reset value of r29 ($sp).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- RegWrite  in  1  write enable.
- WriteReg  in  5  destination register index, from the destination-select mux.
- WriteData  in  DATA_W  data to write.
- ReadReg1  in  5  read index A (RS).
- ReadReg2  in  5  read index B (RT).
- ReadData1  out  DATA_W  contents of ReadReg1.
- ReadData2  out  DATA_W  contents of ReadReg2.
- DumpStart  in  1  request a full dump; sampled only in IDLE.
- DumpReady  in  1  consumer accepts the current beat.
- DumpValid  out  1  beat valid.
- DumpIndex  out  5  register index of the current beat.
- DumpData  out  DATA_W  register value of the current beat.
- DumpBusy  out  1  high in LOAD and SEND.
- DumpDone  out  1  one-cycle pulse after the last beat.

Behaviour:
- Reset: async reset clears all registers to 0, except r29 = SP_RESET.
  - Dump outputs reset to 0: DumpValid, DumpIndex, DumpData, DumpBusy, DumpDone.
  - FSM returns to IDLE. Holds for reset asserted mid-dump; the dump is abandoned, not resumed.
- Write: on the rising edge when RegWrite=1 and WriteReg!=0, reg[WriteReg] <= WriteData.
  - Writes to r0 are discarded; r0 always reads 0.
- Read: ReadData1/2 are combinational from the current register contents.
  - A write on the same edge is visible only after that edge (see Optional Feature).
- FSM states: IDLE, LOAD, SEND, DONE.
  - IDLE: DumpStart=1 at an edge -> LOAD; DumpIndex <= 0.
  - LOAD (1 cycle): DumpData <= reg[DumpIndex] (pre-edge contents); DumpValid <= 1 -> SEND.
  - SEND: DumpValid=1. DumpIndex and DumpData are held stable while DumpReady=0.
  - SEND, on handshake (Valid & Ready):
    - If DumpIndex != 31: DumpIndex <= DumpIndex+1; DumpData <= reg[DumpIndex+1]; stay in SEND. No bubble between beats.
    - If DumpIndex = 31: DumpValid <= 0 -> DONE.
  - DONE: DumpDone=1 for exactly one cycle; DumpBusy=0 -> IDLE.
- Latency: DumpStart sampled at edge n; first beat valid after edge n+1. Full dump with DumpReady tied high: 32 beats on consecutive cycles.
- Snapshot rule: DumpData is captured when a beat is loaded. A later write to that register does not change the presented beat.
  - A write to a not-yet-dumped register before its beat is loaded is reflected in that beat.
- DumpStart while DumpBusy=1 or in DONE: ignored, no queueing.
- The dump never blocks register writes or reads. RegWrite has no interaction with the dump handshake.
- DumpIndex wraps only by returning to IDLE; it never counts past 31.

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined: ReadDataX = WriteData when RegWrite=1 and WriteReg=ReadRegX and WriteReg!=0. This is a same-cycle write-through to the read ports. The dump engine is unaffected and still uses pre-edge contents.
- Undefined: read ports always show stored contents; the new value is visible the cycle after the write edge.

Test Plan:
- Reset, then ReadReg1=29, ReadReg2=5 -> ReadData1=227, ReadData2=0; all Dump* outputs = 0.
- Write r8=0xDEADBEEF, then r0=0x1234 -> next cycle ReadReg1=8 gives 0xDEADBEEF; ReadReg2=0 gives 0.
- RegWrite with WriteReg=9, WriteData=0x55, ReadReg1=9, same cycle:
  - Without REGBANK_BYPASS_EN -> ReadData1=0, then 0x55 after the edge.
  - With REGBANK_BYPASS_EN -> ReadData1=0x55 immediately.
- DumpStart pulse, DumpReady=1, r8 preloaded 0xDEADBEEF:
  - 32 consecutive beats, DumpIndex 0..31.
  - Beat 8 = 0xDEADBEEF, beat 29 = 227, others 0.
  - DumpDone high exactly one cycle after beat 31; DumpBusy low in that cycle.
- Backpressure: DumpReady=0 for 3 cycles while DumpIndex=8; write r8=0x77 during the stall.
  - DumpIndex stays 8 and DumpData stays 0xDEADBEEF throughout.
  - Next beat is index 9; ReadReg1=8 gives 0x77.
  - A DumpStart pulse during the stall has no effect.
- Reset asserted while DumpIndex=12 -> DumpValid/DumpBusy drop to 0 without waiting for an edge; r29 = 227.
  - A new DumpStart after reset restarts from index 0.
